// File: rtl/modulation_generator.sv
// modulation_generator: LFSR-keyed ASK/BPSK waveforms from a DDS carrier, stepped by a bit-rate divider.
// Defining MODGEN_FSK_EN adds the registered FSK output keyed between carrier_a and carrier_b.
module modulation_generator #(
  parameter int         BAUD_DIV = 50_000_000,
  parameter logic [4:0] SEED     = 5'b00001
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        seed_load,
  input  logic [4:0]  seed_val,
  input  logic [11:0] carrier_a,
  input  logic [11:0] carrier_b,
  output logic        lfsr_mod,
  output logic [4:0]  lfsr_state,
  output logic        bit_strobe,
  output logic [11:0] ask_mod,
  output logic [11:0] bpsk_mod,
  output logic [11:0] fsk_mod
);
  localparam logic [25:0] LAST = 26'(BAUD_DIV - 1);
  logic [25:0] cnt;
  logic        wrap;
  logic [11:0] neg_a;
  assign wrap       = enable && cnt == LAST;
  assign bit_strobe = reset_n && wrap;
  assign lfsr_mod   = lfsr_state[0];
  // -2048 has no positive twin in 12 bits, so clamp it to +2047
  assign neg_a      = carrier_a == 12'h800 ? 12'h7FF : 12'(-carrier_a);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      lfsr_state <= SEED;
    end else begin
      cnt <= (seed_load || wrap) ? '0 : enable ? cnt + 26'd1 : cnt;
      if (seed_load)
        lfsr_state <= seed_val == 5'd0 ? 5'b00001 : seed_val;
      else if (lfsr_state == 5'd0)
        lfsr_state <= SEED;
      else if (wrap)
        lfsr_state <= {lfsr_state[0] ^ lfsr_state[2], lfsr_state[4:1]};
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ask_mod  <= '0;
      bpsk_mod <= '0;
    end else begin
      ask_mod  <= lfsr_mod ? carrier_a : 12'h000;
      bpsk_mod <= lfsr_mod ? carrier_a : neg_a;
    end
  end
`ifdef MODGEN_FSK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fsk_mod <= '0;
    else          fsk_mod <= lfsr_mod ? carrier_a : carrier_b;
  end
`else
  logic unused_b;
  assign unused_b = ^carrier_b;
  assign fsk_mod  = 12'h000;
`endif
endmodule

// File: tb/tb_modulation_generator.sv
// tb_modulation_generator: directed checks of modulation_generator with BAUD_DIV=4.
module tb_modulation_generator;
  logic        clk = 1'b0;
  logic        reset_n, enable, seed_load;
  logic [4:0]  seed_val;
  logic [11:0] carrier_a, carrier_b;
  logic        lfsr_mod, bit_strobe;
  logic [4:0]  lfsr_state;
  logic [11:0] ask_mod, bpsk_mod, fsk_mod;
  int total = 0;
  int bad = 0;
  logic [4:0] seq [6] = '{5'b00001, 5'b10000, 5'b01000, 5'b00100, 5'b10010, 5'b01001};

  modulation_generator #(.BAUD_DIV(4), .SEED(5'b00001)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .seed_load(seed_load),
    .seed_val(seed_val), .carrier_a(carrier_a), .carrier_b(carrier_b),
    .lfsr_mod(lfsr_mod), .lfsr_state(lfsr_state), .bit_strobe(bit_strobe),
    .ask_mod(ask_mod), .bpsk_mod(bpsk_mod), .fsk_mod(fsk_mod)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [11:0] fsk_exp(input logic b, input logic [11:0] a, input logic [11:0] s);
`ifdef MODGEN_FSK_EN
    return b ? a : s;
`else
    return 12'h000;
`endif
  endfunction

  initial begin
    logic b;
    reset_n = 1'b0; enable = 1'b0; seed_load = 1'b0; seed_val = 5'd0;
    carrier_a = 12'h123; carrier_b = 12'h200;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(lfsr_state), 32'h01);
    check("rst_mod", 32'(lfsr_mod), 32'h1);
    check("rst_strobe", 32'(bit_strobe), 32'h0);
    check("rst_ask", 32'(ask_mod), 32'h0);
    check("rst_bpsk", 32'(bpsk_mod), 32'h0);
    check("rst_fsk", 32'(fsk_mod), 32'h0);
    reset_n = 1'b1; enable = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      b = seq[(k - 1) / 4][0];
      check($sformatf("strobe_k%0d", k), 32'(bit_strobe), 32'(k % 4 == 3));
      check($sformatf("state_k%0d", k), 32'(lfsr_state), 32'(seq[k / 4]));
      check($sformatf("ask_k%0d", k), 32'(ask_mod), b ? 32'h123 : 32'h000);
      check($sformatf("bpsk_k%0d", k), 32'(bpsk_mod), b ? 32'h123 : 32'hEDD);
      check($sformatf("fsk_k%0d", k), 32'(fsk_mod), 32'(fsk_exp(b, 12'h123, 12'h200)));
    end
    carrier_a = 12'h800;
    step();
    check("ask_800_bit1", 32'(ask_mod), 32'h800);
    check("bpsk_800_bit1", 32'(bpsk_mod), 32'h800);
    repeat (3) step();
    check("state_k24", 32'(lfsr_state), 32'h14);
    step();
    check("ask_bit0", 32'(ask_mod), 32'h000);
    check("bpsk_sat", 32'(bpsk_mod), 32'h7FF);
    step();
    step();
    check("strobe_k27", 32'(bit_strobe), 32'h1);
    seed_load = 1'b1; seed_val = 5'd0;
    #1 check("strobe_with_load", 32'(bit_strobe), 32'h1);
    step();
    seed_load = 1'b0;
    check("load_zero_seed", 32'(lfsr_state), 32'h01);
    check("strobe_k28", 32'(bit_strobe), 32'h0);
    step();
    check("strobe_k29", 32'(bit_strobe), 32'h0);
    step();
    check("strobe_k30", 32'(bit_strobe), 32'h0);
    step();
    check("strobe_k31", 32'(bit_strobe), 32'h1);
    step();
    check("state_k32", 32'(lfsr_state), 32'h10);
    step();
    enable = 1'b0;
    carrier_a = 12'h010; carrier_b = 12'h0F0;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("hold_strobe_%0d", i), 32'(bit_strobe), 32'h0);
      check($sformatf("hold_state_%0d", i), 32'(lfsr_state), 32'h10);
    end
    check("hold_bpsk_track", 32'(bpsk_mod), 32'hFF0);
    check("hold_fsk_track", 32'(fsk_mod), 32'(fsk_exp(1'b0, 12'h010, 12'h0F0)));
    enable = 1'b1;
    step();
    check("resume_strobe_a", 32'(bit_strobe), 32'h0);
    step();
    check("resume_strobe_b", 32'(bit_strobe), 32'h1);
    step();
    check("resume_state", 32'(lfsr_state), 32'h08);
    seed_load = 1'b1; seed_val = 5'b10110;
    step();
    seed_load = 1'b0;
    check("load_seed", 32'(lfsr_state), 32'h16);
    step();
    reset_n = 1'b0;
    #1 check("async_rst_state", 32'(lfsr_state), 32'h01);
    check("async_rst_ask", 32'(ask_mod), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    step();
    check("post_rst_strobe_a", 32'(bit_strobe), 32'h0);
    step();
    check("post_rst_strobe_b", 32'(bit_strobe), 32'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
